// File: rtl/pipelined_prefix_adder_if.sv
// Valid/ready streaming bundle for pipelined_prefix_adder: operand side (in_*) and result side (out_*).
interface pipelined_prefix_adder_if #(
  parameter int WIDTH = 26,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
  );
endinterface

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Knowles (span-doubling) prefix adder/subtractor with valid/ready flow control.
// One precompute register, then one register per group of LVL_PER_STAGE prefix levels.
module pipelined_prefix_adder #(
  parameter int WIDTH         = 26,
  parameter int LVL_PER_STAGE = 2,
  parameter int TAG_W         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipelined_prefix_adder_if.slave bus
);
  localparam int NLVL = $clog2(WIDTH);
  localparam int NGRP = (NLVL + LVL_PER_STAGE - 1) / LVL_PER_STAGE;
  localparam int LAST = NGRP - 1;

  // Position 0 of every G/P vector is bit -1 (the carry-in); P there is tied low so
  // any span reaching it degenerates to a grey cell.
  function automatic logic [2*WIDTH+1:0] knowles_levels(
    input logic [WIDTH:0] g_in,
    input logic [WIDTH:0] p_in,
    input int             lo,
    input int             hi
  );
    logic [WIDTH:0] g_v, p_v, g_n, p_n;
    g_v = g_in;
    p_v = p_in;
    for (int k = lo; k < hi; k++) begin
      g_n = g_v;
      p_n = p_v;
      for (int j = (1 << k); j <= WIDTH; j++) begin
        g_n[j] = g_v[j] | (p_v[j] & g_v[j - (1 << k)]);
        p_n[j] = p_v[j] & p_v[j - (1 << k)];
      end
      g_v = g_n;
      p_v = p_n;
    end
    return {g_v, p_v};
  endfunction

  logic             adv_s;
  logic [WIDTH-1:0] b_x_s;
  logic             c0_s;
  logic [WIDTH:0]   g0_s;
  logic [WIDTH:0]   p0_s;

  logic             vld_r [NGRP];
  logic [WIDTH:0]   g_r   [NGRP];
  logic [WIDTH:0]   p_r   [NGRP];
  logic [WIDTH-1:0] hp_r  [NGRP];
  logic [TAG_W-1:0] tag_r [NGRP];

  logic [WIDTH:0]   grp_g_s [NGRP];
  logic [WIDTH:0]   grp_p_s [NGRP];

  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic             ovf_s;
  logic             zero_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_sum_r;
  logic             out_cout_r;
  logic             out_ovf_r;
  logic             out_zero_r;
  logic [TAG_W-1:0] out_tag_r;

  assign adv_s = ~out_valid_r | bus.out_ready;

  // Operand precompute: subtraction inverts B and the carry-in.
  always_comb begin
    b_x_s = bus.in_b ^ {WIDTH{bus.in_sub}};
    c0_s  = bus.in_cin ^ bus.in_sub;
    g0_s  = {bus.in_a & b_x_s, c0_s};
    p0_s  = {bus.in_a ^ b_x_s, 1'b0};
  end

  // Prefix levels for every register group.
  always_comb begin
    for (int s = 0; s < NGRP; s++) begin
      {grp_g_s[s], grp_p_s[s]} = knowles_levels(
        g_r[s], p_r[s], s * LVL_PER_STAGE,
        (((s + 1) * LVL_PER_STAGE) < NLVL) ? ((s + 1) * LVL_PER_STAGE) : NLVL);
    end
  end

  // Result formation in the last group; cout still folds in bit -1 because a
  // power-of-two span stops one position short of it.
  always_comb begin
    sum_s  = hp_r[LAST] ^ grp_g_s[LAST][WIDTH-1:0];
    cout_s = grp_g_s[LAST][WIDTH] | (grp_p_s[LAST][WIDTH] & grp_g_s[LAST][0]);
    ovf_s  = cout_s ^ grp_g_s[LAST][WIDTH-1];
    zero_s = ~|sum_s;
  end

  // Lock-step pipeline: every stage advances together or holds together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NGRP; s++) begin
        vld_r[s] <= 1'b0;
        g_r[s]   <= '0;
        p_r[s]   <= '0;
        hp_r[s]  <= '0;
        tag_r[s] <= '0;
      end
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_cout_r  <= 1'b0;
      out_ovf_r   <= 1'b0;
      out_zero_r  <= 1'b0;
      out_tag_r   <= '0;
    end else if (adv_s) begin
      vld_r[0] <= bus.in_valid;
      if (bus.in_valid) begin
        g_r[0]   <= g0_s;
        p_r[0]   <= p0_s;
        hp_r[0]  <= p0_s[WIDTH:1];
        tag_r[0] <= bus.in_tag;
      end
      for (int s = 1; s < NGRP; s++) begin
        vld_r[s] <= vld_r[s-1];
        if (vld_r[s-1]) begin
          g_r[s]   <= grp_g_s[s-1];
          p_r[s]   <= grp_p_s[s-1];
          hp_r[s]  <= hp_r[s-1];
          tag_r[s] <= tag_r[s-1];
        end
      end
      out_valid_r <= vld_r[LAST];
      if (vld_r[LAST]) begin
        out_sum_r  <= sum_s;
        out_cout_r <= cout_s;
        out_ovf_r  <= ovf_s;
        out_zero_r <= zero_s;
        out_tag_r  <= tag_r[LAST];
      end
    end
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_cout  = out_cout_r;
  assign bus.out_ovf   = out_ovf_r;
  assign bus.out_zero  = out_zero_r;
  assign bus.out_tag   = out_tag_r;
endmodule
